// File: rtl/riscv_defs_pkg.sv
// Shared core constants used across the pipeline stages.
// Fetch-stage defaults live here so IF and its testbench agree.
package riscv_defs;

  localparam int XLEN       = 32;
  localparam int ILEN       = 32;
  localparam int INST_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DW-1:0]            data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [DW-1:0]            data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q;
  logic [PW-1:0] rp_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rp_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wp_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + PW'(1);
      if (do_pop)  rp_q <= rp_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, prefetch buffer.
// Jumps flush the buffer and discard responses still in flight.
module if_fetch_unit #(
  parameter int            AW        = riscv_defs::XLEN,
  parameter int            DW        = riscv_defs::ILEN,
  parameter logic [AW-1:0] RESET_PC  = AW'(riscv_defs::RESET_PC),
  parameter logic [DW-1:0] NOP_INST  = DW'(riscv_defs::NOP_INST),
  parameter int            BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jump_en_i,
  input  logic [AW-1:0] jump_addr_i,
  input  logic          hold_i,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_rvalid_i,
  input  logic [DW-1:0] imem_rdata_i,
  output logic [DW-1:0] inst_o,
  output logic [AW-1:0] inst_addr_o,
  output logic          inst_valid_o
);

  import riscv_defs::*;

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int EW = AW + DW;

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] last_q;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] aq_cnt, ib_cnt;
  logic          aq_full, aq_empty;
  logic          ib_full, ib_empty;
  logic [AW-1:0] aq_head;
  logic [EW-1:0] ib_head;
  logic [CW:0]   used;
  logic          issue;
  logic          keep;
  logic          ib_pop;

  // Credits cover both in-flight requests and buffered words.
  assign used  = {1'b0, aq_cnt} + {1'b0, ib_cnt};
  assign issue = rst && !jump_en_i && !aq_full && !ib_full
              && (used < (CW+1)'(BUF_DEPTH));
  assign keep  = imem_rvalid_i && !jump_en_i && !aq_empty
              && (disc_q == '0);

  assign inst_valid_o = !ib_empty && !jump_en_i;
  assign ib_pop       = inst_valid_o && !hold_i;
  assign inst_o       = inst_valid_o ? ib_head[DW-1:0] : NOP_INST;
  assign inst_addr_o  = ib_empty ? last_q : ib_head[EW-1:DW];
  assign imem_req_o   = issue;
  assign imem_addr_o  = pc_q;

  sync_fifo #(.DW(AW), .DEPTH(BUF_DEPTH)) u_addr_q (
    .clk     (clk),
    .rst     (rst),
    .push_i  (issue),
    .data_i  (pc_q),
    .pop_i   (imem_rvalid_i),
    .flush_i (1'b0),
    .data_o  (aq_head),
    .full_o  (aq_full),
    .empty_o (aq_empty),
    .count_o (aq_cnt)
  );

  sync_fifo #(.DW(EW), .DEPTH(BUF_DEPTH)) u_inst_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (keep),
    .data_i  ({aq_head, imem_rdata_i}),
    .pop_i   (ib_pop),
    .flush_i (jump_en_i),
    .data_o  (ib_head),
    .full_o  (ib_full),
    .empty_o (ib_empty),
    .count_o (ib_cnt)
  );

  // On a jump every request still in flight after this cycle is stale.
  always_comb begin
    pc_d   = pc_q;
    disc_d = disc_q;
    if (jump_en_i) begin
      pc_d   = jump_addr_i & ~AW'(3);
      disc_d = aq_cnt - CW'(imem_rvalid_i);
    end else begin
      if (issue) pc_d = pc_q + AW'(INST_BYTES);
      if (imem_rvalid_i && disc_q != '0) disc_d = disc_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      disc_q <= '0;
      last_q <= RESET_PC;
    end else begin
      pc_q   <= pc_d;
      disc_q <= disc_d;
      if (!ib_empty) last_q <= ib_head[EW-1:DW];
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a fixed-latency imem model.
// Each scenario task drives its stimulus and checks inline.
module tb_if_fetch_unit;
  import riscv_defs::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        hold = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_valid;

  if_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .jump_en_i     (jump_en),
    .jump_addr_i   (jump_addr),
    .hold_i        (hold),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .inst_o        (inst),
    .inst_addr_o   (inst_addr),
    .inst_valid_o  (inst_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] reqs[$];
  logic [31:0] pa[$];
  logic [31:0] pd[$];
  int cyc  = 0;
  int lat  = 1;
  int nvec = 0;
  int nerr = 0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_0000;
  endfunction

  // Mid-cycle: log requests into the memory model and record pops.
  task automatic sample();
    @(negedge clk);
    if (imem_req) begin
      pend.push_back('{imem_addr, cyc + lat});
      reqs.push_back(imem_addr);
    end
    if (inst_valid && !hold && !jump_en) begin
      pa.push_back(inst_addr);
      pd.push_back(inst);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
    rvalid = 1'b0;
    rdata  = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      rvalid = 1'b1;
      rdata  = mdata(pend[0].a);
      pend.delete(0);
    end
  endtask

  task automatic clear_logs();
    reqs.delete();
    pa.delete();
    pd.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    jump_en = 1'b0;
    hold = 1'b0;
    sample();
    adv();
    pend.delete();
    rvalid = 1'b0;
    rdata = '0;
    sample();
    adv();
    rst = 1'b1;
    clear_logs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      adv();
    end
  endtask

  task automatic test_reset();
    lat = 1;
    rst = 1'b0;
    sample();
    adv();
    sample();
    nvec++;
    if (imem_req !== 1'b0) begin
      nerr++;
      $display("FAIL rst_req got=%b exp=0", imem_req);
    end
    nvec++;
    if (inst_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rst_valid got=%b exp=0", inst_valid);
    end
    nvec++;
    if (inst !== 32'h0000_0013) begin
      nerr++;
      $display("FAIL rst_inst got=%h exp=00000013", inst);
    end
    nvec++;
    if (inst_addr !== 32'h0) begin
      nerr++;
      $display("FAIL rst_addr got=%h exp=00000000", inst_addr);
    end
    adv();
    rst = 1'b1;
    clear_logs();
  endtask

  task automatic test_lat1();
    logic        e_req [6];
    logic [31:0] e_ra  [6];
    logic        e_v   [6];
    logic [31:0] e_ia  [6];
    e_req = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    e_ra  = '{32'h0, 32'h4, 32'h0, 32'h8, 32'hC, 32'h0};
    e_v   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    e_ia  = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h8};
    lat = 1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      sample();
      nvec++;
      if (imem_req !== e_req[k] ||
          (e_req[k] && imem_addr !== e_ra[k])) begin
        nerr++;
        $display("FAIL lat1_req c%0d got=%b/%h exp=%b/%h",
                 k, imem_req, imem_addr, e_req[k], e_ra[k]);
      end
      nvec++;
      if (inst_valid !== e_v[k] || inst_addr !== e_ia[k]) begin
        nerr++;
        $display("FAIL lat1_out c%0d got=%b/%h exp=%b/%h",
                 k, inst_valid, inst_addr, e_v[k], e_ia[k]);
      end
      nvec++;
      if (inst !== (e_v[k] ? mdata(e_ia[k]) : NOP_INST)) begin
        nerr++;
        $display("FAIL lat1_inst c%0d got=%h exp=%h", k, inst,
                 e_v[k] ? mdata(e_ia[k]) : NOP_INST);
      end
      adv();
    end
  endtask

  task automatic test_hold();
    logic [31:0] exp_a [4];
    exp_a = '{32'h0, 32'h4, 32'h8, 32'hC};
    lat = 3;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      hold = (k >= 3 && k <= 7);
      sample();
      nvec++;
      if (reqs.size() - pa.size() > 2) begin
        nerr++;
        $display("FAIL hold_credit c%0d got=%0d exp<=2",
                 k, reqs.size() - pa.size());
      end
      if (k >= 5 && k <= 7) begin
        nvec++;
        if (inst_valid !== 1'b1 || inst_addr !== 32'h0 ||
            imem_req !== 1'b0) begin
          nerr++;
          $display("FAIL hold_stable c%0d got=%b/%h/%b exp=1/0/0",
                   k, inst_valid, inst_addr, imem_req);
        end
      end
      adv();
    end
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (i >= pa.size()) begin
        nerr++;
        $display("FAIL hold_seq #%0d got=none exp=%h", i, exp_a[i]);
      end else if (pa[i] !== exp_a[i] || pd[i] !== mdata(exp_a[i])) begin
        nerr++;
        $display("FAIL hold_seq #%0d got=%h/%h exp=%h/%h",
                 i, pa[i], pd[i], exp_a[i], mdata(exp_a[i]));
      end
    end
  endtask

  task automatic test_jump();
    lat = 3;
    do_reset();
    run(2);
    jump_en = 1'b1;
    jump_addr = 32'h100;
    sample();
    nvec++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 ||
        inst !== NOP_INST) begin
      nerr++;
      $display("FAIL jump_cycle got=%b/%b/%h exp=0/0/%h",
               imem_req, inst_valid, inst, NOP_INST);
    end
    adv();
    jump_en = 1'b0;
    run(15);
    nvec++;
    if (reqs.size() < 3 || reqs[2] !== 32'h100) begin
      nerr++;
      $display("FAIL jump_req got=%h exp=00000100",
               reqs.size() < 3 ? 32'hx : reqs[2]);
    end
    nvec++;
    if (pa.size() < 2 || pa[0] !== 32'h100 || pa[1] !== 32'h104 ||
        pd[0] !== mdata(32'h100) || pd[1] !== mdata(32'h104)) begin
      nerr++;
      $display("FAIL jump_seq got=%h,%h exp=00000100,00000104",
               pa.size() > 0 ? pa[0] : 32'hx,
               pa.size() > 1 ? pa[1] : 32'hx);
    end
  endtask

  task automatic test_jump_rvalid_hold();
    lat = 1;
    do_reset();
    run(2);
    jump_en = 1'b1;
    hold = 1'b1;
    jump_addr = 32'h203;
    sample();
    nvec++;
    if (inst_valid !== 1'b0 || inst !== NOP_INST) begin
      nerr++;
      $display("FAIL jrh_cycle got=%b/%h exp=0/%h",
               inst_valid, inst, NOP_INST);
    end
    adv();
    jump_en = 1'b0;
    hold = 1'b0;
    sample();
    nvec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      nerr++;
      $display("FAIL jrh_req got=%b/%h exp=1/00000200",
               imem_req, imem_addr);
    end
    adv();
    run(6);
    nvec++;
    if (pa.size() < 2 || pa[0] !== 32'h200 || pa[1] !== 32'h204 ||
        pd[0] !== mdata(32'h200)) begin
      nerr++;
      $display("FAIL jrh_seq got=%h,%h exp=00000200,00000204",
               pa.size() > 0 ? pa[0] : 32'hx,
               pa.size() > 1 ? pa[1] : 32'hx);
    end
  endtask

  task automatic test_reset_midstream();
    lat = 1;
    do_reset();
    hold = 1'b1;
    run(8);
    sample();
    nvec++;
    if (inst_valid !== 1'b1 || inst_addr !== 32'h0 || imem_req !== 1'b0) begin
      nerr++;
      $display("FAIL mid_full got=%b/%h/%b exp=1/0/0",
               inst_valid, inst_addr, imem_req);
    end
    adv();
    rst = 1'b0;
    hold = 1'b0;
    sample();
    adv();
    pend.delete();
    rvalid = 1'b0;
    rdata = '0;
    sample();
    nvec++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 ||
        inst !== 32'h0000_0013 || inst_addr !== 32'h0) begin
      nerr++;
      $display("FAIL mid_rst got=%b/%b/%h/%h exp=0/0/00000013/0",
               imem_req, inst_valid, inst, inst_addr);
    end
    adv();
    rst = 1'b1;
    clear_logs();
    run(8);
    nvec++;
    if (reqs.size() < 1 || reqs[0] !== 32'h0 || pa.size() < 2 ||
        pa[0] !== 32'h0 || pa[1] !== 32'h4) begin
      nerr++;
      $display("FAIL mid_restart got=%h,%h exp=00000000,00000004",
               pa.size() > 0 ? pa[0] : 32'hx,
               pa.size() > 1 ? pa[1] : 32'hx);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [4];
    exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    lat = 1;
    do_reset();
    jump_en = 1'b1;
    jump_addr = 32'hFFFF_FFF8;
    sample();
    adv();
    jump_en = 1'b0;
    clear_logs();
    run(12);
    nvec++;
    if (reqs.size() < 3 || reqs[1] !== 32'hFFFF_FFFC ||
        reqs[2] !== 32'h0) begin
      nerr++;
      $display("FAIL wrap_req got=%h,%h exp=fffffffc,00000000",
               reqs.size() > 1 ? reqs[1] : 32'hx,
               reqs.size() > 2 ? reqs[2] : 32'hx);
    end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (i >= pa.size()) begin
        nerr++;
        $display("FAIL wrap_seq #%0d got=none exp=%h", i, exp_a[i]);
      end else if (pa[i] !== exp_a[i] || pd[i] !== mdata(exp_a[i])) begin
        nerr++;
        $display("FAIL wrap_seq #%0d got=%h/%h exp=%h/%h",
                 i, pa[i], pd[i], exp_a[i], mdata(exp_a[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_lat1();
    test_hold();
    test_jump();
    test_jump_rvalid_hold();
    test_reset_midstream();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
